status_flag_unit: RTL and testbench
===================================

STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 The unit SHALL have one clock and one reset: clk input 1, rising-edge clock; rst input 1, asynchronous, active-high reset.
REQ-002 PEND_MAX, default 3, SHALL set the maximum in-flight flag-setting instructions tracked.
REQ-003 exe_s input 1 SHALL mean the EXE-stage instruction has its S bit set and is valid.
REQ-004 exe_logic input 1 SHALL mean the EXE instruction is a logical/move op (AND, ORR, EOR, MOV, MVN, TST): C and V are preserved.
REQ-005 alu_res input 32 SHALL be the EXE ALU result; alu_c input 1 its carry-out; alu_v input 1 its overflow.
REQ-006 id_issue_s input 1 SHALL mean the ID instruction sets flags and advances this cycle.
REQ-007 id_cond_uses_flags input 1 SHALL mean the ID instruction has cond != 4'b1110 (AL).
REQ-008 flush input 1 SHALL mean a branch taken in EXE; it squashes ID and EXE.
REQ-009 freeze input 1 SHALL mean a global pipeline stall; the unit holds all state.
REQ-010 status_reg_out output 4 SHALL be the committed flags {Z,C,V,N} at bits [3:0].
REQ-011 flag_hazard output 1 SHALL request that ID stall.
REQ-012 pend_cnt output clog2(PEND_MAX+1) SHALL be the in-flight counter.
REQ-013 pend_err output 1 SHALL be a sticky overflow/underflow error.

Function
REQ-014 Flag computation SHALL be N=alu_res[31] and Z=(alu_res==0); C and V SHALL be alu_c and alu_v when exe_logic=0, otherwise the previous C and V.
REQ-015 status_reg_out SHALL update on the rising edge when exe_s=1, freeze=0 and flush=0, with 1-cycle latency; otherwise it SHALL hold.
REQ-016 The exe_s instruction SHALL commit even if flush is asserted in the same cycle only when the flush originates from an older branch; flush is defined as killing EXE, so no update occurs on flush.
REQ-017 On each cycle with freeze=0: inc=id_issue_s&~flush; dec=exe_s.
REQ-018 pend_cnt SHALL become cnt+1 when inc&~dec, cnt-1 when dec&~inc, and be unchanged when both or neither are set.
REQ-019 On flush (freeze=0), pend_cnt SHALL become 0, since the ID and EXE instructions are both squashed; flush SHALL take priority over inc and dec.
REQ-020 Increment at cnt=PEND_MAX SHALL saturate and set pend_err; decrement at 0 SHALL hold 0 and set pend_err.
REQ-021 flag_hazard SHALL be combinational: id_cond_uses_flags & (pend_cnt!=0); it SHALL be 0 when flush=1.
REQ-022 freeze SHALL hold status_reg_out, pend_cnt and pend_err regardless of other inputs.
REQ-023 flag_hazard SHALL still be driven during freeze, from the held pend_cnt.

Reset
REQ-024 rst SHALL asynchronously clear status_reg_out to 4'b0000, pend_cnt to 0 and pend_err to 0.
REQ-025 rst asserted mid-operation SHALL discard any pending update.
REQ-026 The first update after rst deassertion SHALL occur on the first rising edge that sees exe_s=1.

Structure
REQ-027 A shared package SHALL hold: flag bit indices (Z=3, C=2, V=1, N=0), the AL condition code 4'b1110, and the logical-op command list.
REQ-028 One sub-module, pend_counter (an up/down saturating counter with sticky error), SHALL be instantiated; flag logic and register SHALL be inline.
REQ-029 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-030 A bench SHALL cover: exe_s=1, exe_logic=0, alu_res=0, alu_c=1, alu_v=0 -> next cycle status_reg_out=4'b1100.
REQ-031 A bench SHALL cover: flags=4'b0110, then exe_s=1, exe_logic=1, alu_res=32'h8000_0000 -> status_reg_out=4'b0111 (C and V kept).
REQ-032 A bench SHALL cover: id_issue_s=1 at cycle 0, then id_cond_uses_flags=1 at cycle 1 -> flag_hazard=1; exe_s at cycle 1 -> pend_cnt=0 at cycle 2 and flag_hazard=0.
REQ-033 A bench SHALL cover: pend_cnt=2, then flush=1 together with id_issue_s=1 -> pend_cnt=0, and status_reg_out is unchanged.
REQ-034 A bench SHALL cover: PEND_MAX=3, four issues with no retire -> pend_cnt=3 and pend_err=1; then exe_s at cnt=0 -> pend_err stays 1.
REQ-035 A bench SHALL cover: freeze=1 with exe_s=1 and id_issue_s=1 -> all state held; then rst pulsed asynchronously mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the status flag unit: flag bit positions inside
// status_reg_out, the "always" condition code, and the data-processing
// opcodes that leave C and V untouched.
package status_flag_unit_pkg;

  // Bit positions of each flag in the {Z,C,V,N} status word.
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagN = 0;

  // Condition field value meaning "execute always"; anything else reads flags.
  localparam logic [3:0] CondAl = 4'b1110;

  // Data-processing opcodes whose flag update keeps the previous C and V.
  typedef enum logic [3:0] {
    OpAnd = 4'b0000,
    OpEor = 4'b0001,
    OpTst = 4'b1000,
    OpOrr = 4'b1100,
    OpMov = 4'b1101,
    OpMvn = 4'b1111
  } logic_op_e;

  // Decoder helper: does this opcode belong to the logical/move group.
  function automatic logic is_logic_op(input logic [3:0] opcode);
    unique case (opcode)
      OpAnd, OpEor, OpTst, OpOrr, OpMov, OpMvn: is_logic_op = 1'b1;
      default:                                  is_logic_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/status_flag_unit_if.sv
// Pipeline-side signal bundle of the status flag unit.
// master: pipeline control (drives EXE/ID/flush/freeze, observes flags/hazard)
// slave : the status flag unit itself
interface status_flag_unit_if #(
  parameter int unsigned PEND_MAX = 3
);
  localparam int unsigned CntW = $clog2(PEND_MAX + 1);

  logic            exe_s;               // EXE instruction valid with S bit
  logic            exe_logic;           // EXE is a logical/move op
  logic [31:0]     alu_res;             // EXE ALU result
  logic            alu_c;               // EXE ALU carry-out
  logic            alu_v;               // EXE ALU overflow
  logic            id_issue_s;          // ID flag-setter advances this cycle
  logic            id_cond_uses_flags;  // ID instruction is conditional
  logic            flush;               // taken branch in EXE, kills ID and EXE
  logic            freeze;              // global stall
  logic [3:0]      status_reg_out;      // committed {Z,C,V,N}
  logic            flag_hazard;         // ID must stall
  logic [CntW-1:0] pend_cnt;            // in-flight flag setters
  logic            pend_err;            // sticky over/underflow

  modport master (
    output exe_s, exe_logic, alu_res, alu_c, alu_v, id_issue_s, id_cond_uses_flags,
           flush, freeze,
    input  status_reg_out, flag_hazard, pend_cnt, pend_err
  );

  modport slave (
    input  exe_s, exe_logic, alu_res, alu_c, alu_v, id_issue_s, id_cond_uses_flags,
           flush, freeze,
    output status_reg_out, flag_hazard, pend_cnt, pend_err
  );

endinterface

// File: rtl/status_flag_unit_pend_counter.sv
// pend_counter: up/down counter of in-flight flag-setting instructions.
// Saturates at MAX and at zero; any attempt to pass either bound sets a sticky
// error bit. clear zeroes the count (error kept); hold freezes everything.
// Ports: clk, rst (async, active-high), hold, clear, inc, dec, cnt, err.
module pend_counter #(
  parameter int unsigned MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hold,
  input  logic                         clear,
  input  logic                         inc,
  input  logic                         dec,
  output logic [$clog2(MAX + 1)-1:0]   cnt,
  output logic                         err
);

  localparam int unsigned CntW = $clog2(MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (!hold) begin
      if (clear) begin
        // Clear wins over inc/dec: every tracked instruction was squashed.
        cnt_d = '0;
      end else if (inc && !dec) begin
        if (cnt_q == CntMax) err_d = 1'b1;
        else                 cnt_d = cnt_q + CntOne;
      end else if (dec && !inc) begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: rtl/status_flag_unit.sv
// status_flag_unit: holds the committed {Z,C,V,N} flags and tracks flag
// setters still in flight so that conditional instructions in ID can stall.
// Ports: clk, rst (async, active-high); bus (slave side of status_flag_unit_if)
// carrying EXE result/flags, ID issue info, flush/freeze and the flag,
// hazard, pending-count and error outputs.
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int unsigned PEND_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  status_flag_unit_if.slave        bus
);

  localparam int unsigned CntW = $clog2(PEND_MAX + 1);

  logic [3:0]      flags_q, flags_d;
  logic [CntW-1:0] cnt;
  logic            err;
  logic            commit;

  // A flushed EXE instruction is dead, so it never commits flags.
  assign commit = bus.exe_s && !bus.freeze && !bus.flush;

  always_comb begin
    flags_d = flags_q;
    if (commit) begin
      flags_d[FlagN] = bus.alu_res[31];
      flags_d[FlagZ] = (bus.alu_res == 32'd0);
      if (!bus.exe_logic) begin
        flags_d[FlagC] = bus.alu_c;
        flags_d[FlagV] = bus.alu_v;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 4'b0000;
    else     flags_q <= flags_d;
  end

  // A squashed ID issue never enters the pipeline, so it is not counted.
  pend_counter #(
    .MAX (PEND_MAX)
  ) u_pend_counter (
    .clk   (clk),
    .rst   (rst),
    .hold  (bus.freeze),
    .clear (bus.flush),
    .inc   (bus.id_issue_s && !bus.flush),
    .dec   (bus.exe_s),
    .cnt   (cnt),
    .err   (err)
  );

  assign bus.status_reg_out = flags_q;
  assign bus.pend_cnt       = cnt;
  assign bus.pend_err       = err;
  // Still driven under freeze, from the held count.
  assign bus.flag_hazard    = bus.id_cond_uses_flags && (cnt != '0) && !bus.flush;

endmodule

// File: tb/tb_status_flag_unit.sv
module tb_status_flag_unit;

  localparam int unsigned PendMax = 3;

  typedef struct {
    bit          rst;
    bit          exe_s;
    bit          exe_logic;
    logic [31:0] res;
    bit          c;
    bit          v;
    bit          issue;
    bit          cond;
    bit          flush;
    bit          freeze;
  } stim_t;

  typedef struct {
    logic [3:0] status;
    int         cnt;
    bit         err;
    bit         haz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  status_flag_unit_if #(.PEND_MAX(PendMax)) bus ();

  status_flag_unit #(.PEND_MAX(PendMax)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  // Reference model state: flags as individual bits, count as a plain integer.
  bit m_z, m_c, m_v, m_n;
  int m_cnt;
  bit m_err;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.exe_s = 0; s.exe_logic = 0; s.res = 32'd0; s.c = 0; s.v = 0;
    s.issue = 0; s.cond = 0; s.flush = 0; s.freeze = 0;
    return s;
  endfunction

  // One clock cycle: apply stimulus shortly after the rising edge, record what
  // the outputs must show during this cycle, then advance the model.
  task automatic cycle(input stim_t s);
    exp_t e;
    int   delta;
    @(posedge clk);
    #1;
    rst                    = s.rst;
    bus.exe_s              = s.exe_s;
    bus.exe_logic          = s.exe_logic;
    bus.alu_res            = s.res;
    bus.alu_c              = s.c;
    bus.alu_v              = s.v;
    bus.id_issue_s         = s.issue;
    bus.id_cond_uses_flags = s.cond;
    bus.flush              = s.flush;
    bus.freeze             = s.freeze;
    if (s.rst) begin
      {m_z, m_c, m_v, m_n} = 4'b0000;
      m_cnt = 0;
      m_err = 0;
    end
    e.status = {m_z, m_c, m_v, m_n};
    e.cnt    = m_cnt;
    e.err    = m_err;
    e.haz    = s.cond && (m_cnt != 0) && !s.flush;
    exp_q.push_back(e);
    if (!s.rst && !s.freeze) begin
      if (s.exe_s && !s.flush) begin
        m_z = (s.res == 32'd0);
        m_n = s.res[31];
        if (!s.exe_logic) begin
          m_c = s.c;
          m_v = s.v;
        end
      end
      if (s.flush) begin
        m_cnt = 0;
      end else begin
        delta = int'(s.issue) - int'(s.exe_s);
        m_cnt = m_cnt + delta;
        if (m_cnt > int'(PendMax)) begin m_cnt = PendMax; m_err = 1; end
        if (m_cnt < 0)             begin m_cnt = 0;       m_err = 1; end
      end
    end
  endtask

  // Scoreboard monitor: each cycle's outputs are compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("status_reg_out", int'(bus.status_reg_out), int'(e.status));
        check("pend_cnt", int'(bus.pend_cnt), e.cnt);
        check("pend_err", int'(bus.pend_err), int'(e.err));
        check("flag_hazard", int'(bus.flag_hazard), int'(e.haz));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    bus.exe_s = 0; bus.exe_logic = 0; bus.alu_res = '0; bus.alu_c = 0; bus.alu_v = 0;
    bus.id_issue_s = 0; bus.id_cond_uses_flags = 0; bus.flush = 0; bus.freeze = 0;
    m_z = 0; m_c = 0; m_v = 0; m_n = 0; m_cnt = 0; m_err = 0;

    s = idle(); s.rst = 1;
    cycle(s);
    cycle(s);
    cycle(idle());

    // Issue then retire; conditional in ID stalls only while one is in flight.
    s = idle(); s.issue = 1; cycle(s);
    s = idle(); s.cond = 1; s.exe_s = 1; s.res = 32'd5; cycle(s);
    @(negedge clk);
    check("hazard_inflight", int'(bus.flag_hazard), 1);
    check("cnt_inflight", int'(bus.pend_cnt), 1);
    s = idle(); s.cond = 1; cycle(s);
    @(negedge clk);
    check("cnt_retired", int'(bus.pend_cnt), 0);
    check("hazard_retired", int'(bus.flag_hazard), 0);

    // Arithmetic zero result with carry.
    s = idle(); s.exe_s = 1; s.issue = 1; s.res = 32'd0; s.c = 1; s.v = 0; cycle(s);
    cycle(idle());
    @(negedge clk);
    check("flags_zero_carry", int'(bus.status_reg_out), 4'b1100);

    // Logical op keeps C and V.
    s = idle(); s.exe_s = 1; s.issue = 1; s.res = 32'd1; s.c = 1; s.v = 1; cycle(s);
    s = idle(); s.exe_s = 1; s.issue = 1; s.exe_logic = 1; s.res = 32'h8000_0000; cycle(s);
    @(negedge clk);
    check("flags_before_logic", int'(bus.status_reg_out), 4'b0110);
    cycle(idle());
    @(negedge clk);
    check("flags_logic_keep_cv", int'(bus.status_reg_out), 4'b0111);

    // Flush with a concurrent issue empties the count and blocks the commit.
    s = idle(); s.issue = 1; cycle(s); cycle(s);
    s = idle(); s.flush = 1; s.issue = 1; s.exe_s = 1; s.res = 32'd0; s.cond = 1; cycle(s);
    @(negedge clk);
    check("cnt_before_flush", int'(bus.pend_cnt), 2);
    check("hazard_masked_by_flush", int'(bus.flag_hazard), 0);
    cycle(idle());
    @(negedge clk);
    check("cnt_after_flush", int'(bus.pend_cnt), 0);
    check("flags_after_flush", int'(bus.status_reg_out), 4'b0111);

    // Overflow at PendMax, then underflow at zero.
    s = idle(); s.issue = 1;
    cycle(s); cycle(s); cycle(s);
    cycle(s);
    @(negedge clk);
    check("cnt_full_no_err", int'(bus.pend_err), 0);
    s = idle(); s.flush = 1; cycle(s);
    @(negedge clk);
    check("cnt_saturated", int'(bus.pend_cnt), 3);
    check("err_on_overflow", int'(bus.pend_err), 1);
    s = idle(); s.exe_s = 1; s.exe_logic = 1; s.res = 32'h8000_0000; cycle(s);
    cycle(idle());
    @(negedge clk);
    check("cnt_underflow_hold", int'(bus.pend_cnt), 0);
    check("err_sticky", int'(bus.pend_err), 1);

    // Freeze holds everything; asynchronous reset clears at once.
    s = idle(); s.issue = 1; cycle(s);
    s = idle(); s.freeze = 1; s.exe_s = 1; s.issue = 1; s.res = 32'd0; cycle(s);
    cycle(idle());
    @(negedge clk);
    check("freeze_cnt", int'(bus.pend_cnt), 1);
    check("freeze_flags", int'(bus.status_reg_out), 4'b0111);
    s = idle(); s.rst = 1; s.issue = 1; s.cond = 1; cycle(s);
    #1;
    check("rst_flags", int'(bus.status_reg_out), 0);
    check("rst_cnt", int'(bus.pend_cnt), 0);
    check("rst_err", int'(bus.pend_err), 0);
    check("rst_hazard", int'(bus.flag_hazard), 0);
    cycle(idle());

    // Randomized phase against the model.
    for (int i = 0; i < 400; i++) begin
      s           = idle();
      s.rst       = ($urandom_range(0, 149) == 0);
      s.exe_s     = ($urandom_range(0, 2) == 0);
      s.exe_logic = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       s.res = 32'd0;
        1:       s.res = 32'h8000_0000 | $urandom;
        default: s.res = $urandom;
      endcase
      s.c      = $urandom_range(0, 1);
      s.v      = $urandom_range(0, 1);
      s.issue  = $urandom_range(0, 1);
      s.cond   = $urandom_range(0, 1);
      s.flush  = ($urandom_range(0, 9) == 0);
      s.freeze = ($urandom_range(0, 7) == 0);
      cycle(s);
    end

    cycle(idle());
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
